// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared state encoding, frame record and fixed geometry constants for the map frame sequencer
package map_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRIG_C = 3'd1,
    ST_CAM    = 3'd2,
    ST_CORN_L = 3'd3,
    ST_CORN_R = 3'd4,
    ST_COMMIT = 3'd5
  } map_state_e;

  typedef struct packed {
    logic [15:0] cam_x;
    logic [15:0] cam_y;
    logic [15:0] farl_x;
    logic [15:0] farl_y;
    logic [15:0] farr_x;
    logic [15:0] farr_y;
    logic [15:0] nearl_x;
    logic [15:0] nearl_y;
    logic [15:0] nearr_x;
    logic [15:0] nearr_y;
  } map_frame_t;

  localparam logic [15:0] BALL_DEPTH   = 16'd7;
  localparam logic [15:0] NEAR_MAG     = 16'd5;
  localparam logic [15:0] FAR_MAG      = 16'd110;
  localparam logic [15:0] MAP_ORIGIN   = 16'd720;
  localparam logic [15:0] COS_HALF_FOV = 16'd146;

  // Operands never exceed 719, so one conditional subtract is a full mod 360.
  function automatic logic [15:0] wrap360(input logic [15:0] v);
    return (v >= 16'd360) ? v - 16'd360 : v;
  endfunction

endpackage

// File: rtl/map_axis_step.sv
// rtl/map_axis_step.sv - one axis of base +/- s(sign)*((mag*abs)>>5) for two magnitudes sharing one lookup sample
module map_axis_step (
  input  logic [15:0] base_in,
  input  logic [15:0] abs_in,
  input  logic        sign_in,
  input  logic        sub_in,
  input  logic [15:0] mag0_in,
  input  logic [15:0] mag1_in,
  output logic [15:0] res0_out,
  output logic [15:0] res1_out
);

  logic [31:0] prod0;
  logic [31:0] prod1;
  logic [15:0] term0;
  logic [15:0] term1;
  logic        neg;
  logic        unused_prod;

  always_comb begin
    prod0 = {16'd0, mag0_in} * {16'd0, abs_in};
    prod1 = {16'd0, mag1_in} * {16'd0, abs_in};
    term0 = prod0[20:5];
    term1 = prod1[20:5];
    // A negative lookup sign flips the requested operation.
    neg      = sub_in ^ sign_in;
    res0_out = neg ? (base_in - term0) : (base_in + term0);
    res1_out = neg ? (base_in - term1) : (base_in + term1);
  end

  assign unused_prod = ^{prod0[31:21], prod0[4:0], prod1[31:21], prod1[4:0]};

endmodule

// File: rtl/map_frame_sequencer.sv
// rtl/map_frame_sequencer.sv - per-frame camera/frustum sequencer sharing one cos/sin lookup
// Optional heading slew limiting is enabled by defining MAP_SEQ_ANGLE_SLEW_EN.
module map_frame_sequencer
  import map_pkg::*;
#(
  parameter int MAX_SLEW = 5,
  parameter int HALF_FOV = 55
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        new_frame_in,
  input  logic [15:0] ballx_in,
  input  logic [15:0] bally_in,
  input  logic [15:0] angle_in,
  output logic [15:0] trig_angle_out,
  input  logic [15:0] cos_abs_in,
  input  logic [15:0] sin_abs_in,
  input  logic        cos_sign_in,
  input  logic        sin_sign_in,
  output logic [15:0] cam_x_out,
  output logic [15:0] cam_y_out,
  output logic [15:0] farl_x_out,
  output logic [15:0] farl_y_out,
  output logic [15:0] farr_x_out,
  output logic [15:0] farr_y_out,
  output logic [15:0] nearl_x_out,
  output logic [15:0] nearl_y_out,
  output logic [15:0] nearr_x_out,
  output logic [15:0] nearr_y_out,
  output logic        params_valid_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        overrun_out
);

  map_state_e  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] trig_q, trig_d;
  logic [15:0] pos_x_q, pos_x_d;
  logic [15:0] pos_y_q, pos_y_d;
  map_frame_t  shadow_q, shadow_d;
  map_frame_t  pub_q, pub_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;

  logic [15:0] angle_red;
  logic [15:0] eff_angle;
  logic [15:0] x_base, y_base, mag0;
  logic        x_sub, y_sub;
  logic [15:0] x_res0, x_res1, y_res0, y_res1;
  logic        unused_cfg;

`ifdef MAP_SEQ_ANGLE_SLEW_EN
  localparam logic [15:0] SLEW = 16'(MAX_SLEW);
  logic [15:0] diff_fwd;
  logic [15:0] diff_back;
`endif

  always_comb begin
    angle_red = wrap360(angle_in);
`ifdef MAP_SEQ_ANGLE_SLEW_EN
    diff_fwd  = (angle_red >= a_q) ? (angle_red - a_q) : (angle_red + 16'd360 - a_q);
    diff_back = 16'd360 - diff_fwd;
    // Exactly 180 degrees away counts as the positive direction.
    if (diff_fwd == 16'd0) begin
      eff_angle = a_q;
    end else if (diff_fwd <= 16'd180) begin
      eff_angle = wrap360(a_q + ((diff_fwd < SLEW) ? diff_fwd : SLEW));
    end else begin
      eff_angle = wrap360(a_q + 16'd360 - ((diff_back < SLEW) ? diff_back : SLEW));
    end
`else
    eff_angle = angle_red;
`endif
  end

  always_comb begin
    x_base = pos_x_q;
    y_base = pos_y_q;
    x_sub  = 1'b0;
    y_sub  = 1'b1;
    mag0   = BALL_DEPTH;
    // Corners project back from the camera, so the operations swap sense.
    if (state_q != ST_CAM) begin
      x_base = shadow_q.cam_x;
      y_base = shadow_q.cam_y;
      x_sub  = 1'b1;
      y_sub  = 1'b0;
      mag0   = FAR_MAG;
    end
  end

  map_axis_step u_step_x (
    .base_in  (x_base),
    .abs_in   (cos_abs_in),
    .sign_in  (cos_sign_in),
    .sub_in   (x_sub),
    .mag0_in  (mag0),
    .mag1_in  (NEAR_MAG),
    .res0_out (x_res0),
    .res1_out (x_res1)
  );

  map_axis_step u_step_y (
    .base_in  (y_base),
    .abs_in   (sin_abs_in),
    .sign_in  (sin_sign_in),
    .sub_in   (y_sub),
    .mag0_in  (mag0),
    .mag1_in  (NEAR_MAG),
    .res0_out (y_res0),
    .res1_out (y_res1)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    trig_d    = trig_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    shadow_d  = shadow_q;
    pub_d     = pub_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (new_frame_in && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Each state presents the next angle so its lookup result lands one state later.
    case (state_q)
      ST_IDLE: begin
        if (new_frame_in) begin
          state_d = ST_TRIG_C;
          a_d     = eff_angle;
          trig_d  = eff_angle;
          pos_x_d = {5'd0, ballx_in[15:5]} + MAP_ORIGIN;
          pos_y_d = {5'd0, bally_in[15:5]} + MAP_ORIGIN;
        end
      end
      ST_TRIG_C: begin
        state_d = ST_CAM;
        trig_d  = wrap360(a_q + 16'(HALF_FOV));
      end
      ST_CAM: begin
        state_d        = ST_CORN_L;
        shadow_d.cam_x = x_res0;
        shadow_d.cam_y = y_res0;
        trig_d         = wrap360(a_q + 16'd360 - 16'(HALF_FOV));
      end
      ST_CORN_L: begin
        state_d          = ST_CORN_R;
        shadow_d.farl_x  = x_res0;
        shadow_d.farl_y  = y_res0;
        shadow_d.nearl_x = x_res1;
        shadow_d.nearl_y = y_res1;
      end
      ST_CORN_R: begin
        state_d          = ST_COMMIT;
        shadow_d.farr_x  = x_res0;
        shadow_d.farr_y  = y_res0;
        shadow_d.nearr_x = x_res1;
        shadow_d.nearr_y = y_res1;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        pub_d   = shadow_q;
        valid_d = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      a_q       <= 16'd0;
      trig_q    <= 16'd0;
      pos_x_q   <= 16'd0;
      pos_y_q   <= 16'd0;
      shadow_q  <= '0;
      pub_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      trig_q    <= trig_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      shadow_q  <= shadow_d;
      pub_q     <= pub_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign trig_angle_out   = trig_q;
  assign cam_x_out        = pub_q.cam_x;
  assign cam_y_out        = pub_q.cam_y;
  assign farl_x_out       = pub_q.farl_x;
  assign farl_y_out       = pub_q.farl_y;
  assign farr_x_out       = pub_q.farr_x;
  assign farr_y_out       = pub_q.farr_y;
  assign nearl_x_out      = pub_q.nearl_x;
  assign nearl_y_out      = pub_q.nearl_y;
  assign nearr_x_out      = pub_q.nearr_x;
  assign nearr_y_out      = pub_q.nearr_y;
  assign params_valid_out = valid_q;
  assign busy_out         = (state_q != ST_IDLE);
  assign frame_done_out   = done_q;
  assign overrun_out      = overrun_q;

  assign unused_cfg = ^{16'(MAX_SLEW), COS_HALF_FOV, ballx_in[4:0], bally_in[4:0]};

endmodule

// File: tb/tb_map_frame_sequencer.sv
// tb/tb_map_frame_sequencer.sv - randomized self-checking bench for map_frame_sequencer with a trig lookup stub
module tb_map_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_frame = 1'b0;
  logic [15:0] ballx = 16'd0;
  logic [15:0] bally = 16'd0;
  logic [15:0] angle = 16'd0;
  logic [15:0] trig;
  logic [15:0] cos_abs = 16'd0;
  logic [15:0] sin_abs = 16'd0;
  logic        cos_sign = 1'b0;
  logic        sin_sign = 1'b0;
  logic [15:0] cam_x, cam_y, farl_x, farl_y, farr_x, farr_y;
  logic [15:0] nearl_x, nearl_y, nearr_x, nearr_y;
  logic        params_valid, busy, frame_done, overrun;

  int tests = 0;
  int fails = 0;
  int a_model = 0;

  logic [15:0]       got_trig [3];
  logic [9:0][15:0]  got_pre, got_post;
  logic              done_e4, done_e5, done_e6, busy_e4, busy_e5;
  logic [9:0][15:0]  obs;

  always #5 clk = ~clk;

  map_frame_sequencer #(.MAX_SLEW(5), .HALF_FOV(55)) dut (
    .pixel_clk_in     (clk),
    .rst_n_in         (rst_n),
    .new_frame_in     (new_frame),
    .ballx_in         (ballx),
    .bally_in         (bally),
    .angle_in         (angle),
    .trig_angle_out   (trig),
    .cos_abs_in       (cos_abs),
    .sin_abs_in       (sin_abs),
    .cos_sign_in      (cos_sign),
    .sin_sign_in      (sin_sign),
    .cam_x_out        (cam_x),
    .cam_y_out        (cam_y),
    .farl_x_out       (farl_x),
    .farl_y_out       (farl_y),
    .farr_x_out       (farr_x),
    .farr_y_out       (farr_y),
    .nearl_x_out      (nearl_x),
    .nearl_y_out      (nearl_y),
    .nearr_x_out      (nearr_x),
    .nearr_y_out      (nearr_y),
    .params_valid_out (params_valid),
    .busy_out         (busy),
    .frame_done_out   (frame_done),
    .overrun_out      (overrun)
  );

  assign obs = {nearr_y, nearr_x, nearl_y, nearl_x, farr_y, farr_x, farl_y, farl_x, cam_y, cam_x};

  function automatic logic [16:0] stub_cos(input int ang);
    case (ang)
      0:       return {1'b0, 16'd256};
      55:      return {1'b0, 16'd146};
      305:     return {1'b0, 16'd146};
      default: return {ang[0], 16'((ang * 73 + 19) % 257)};
    endcase
  endfunction

  function automatic logic [16:0] stub_sin(input int ang);
    case (ang)
      0:       return {1'b0, 16'd0};
      55:      return {1'b0, 16'd210};
      305:     return {1'b1, 16'd210};
      default: return {ang[1], 16'((ang * 41 + 7) % 257)};
    endcase
  endfunction

  always @(posedge clk) begin
    {cos_sign, cos_abs} <= stub_cos(int'(trig));
    {sin_sign, sin_abs} <= stub_sin(int'(trig));
  end

  function automatic int sg(input logic [16:0] v);
    return v[16] ? -1 : 1;
  endfunction

  function automatic int mg(input logic [16:0] v);
    return int'(v[15:0]);
  endfunction

  function automatic logic [9:0][15:0] model(input int bx, input int by, input int a);
    logic [16:0]      c0, s0, cl, sl, cr, sr;
    int               cx, cy;
    logic [9:0][15:0] r;
    c0 = stub_cos(a);            s0 = stub_sin(a);
    cl = stub_cos((a + 55) % 360);  sl = stub_sin((a + 55) % 360);
    cr = stub_cos((a + 305) % 360); sr = stub_sin((a + 305) % 360);
    cx = (bx >> 5) + 720 + sg(c0) * ((7 * mg(c0)) >> 5);
    cy = (by >> 5) + 720 - sg(s0) * ((7 * mg(s0)) >> 5);
    r[0] = 16'(cx);
    r[1] = 16'(cy);
    r[2] = 16'(cx - sg(cl) * ((110 * mg(cl)) >> 5));
    r[3] = 16'(cy + sg(sl) * ((110 * mg(sl)) >> 5));
    r[4] = 16'(cx - sg(cr) * ((110 * mg(cr)) >> 5));
    r[5] = 16'(cy + sg(sr) * ((110 * mg(sr)) >> 5));
    r[6] = 16'(cx - sg(cl) * ((5 * mg(cl)) >> 5));
    r[7] = 16'(cy + sg(sl) * ((5 * mg(sl)) >> 5));
    r[8] = 16'(cx - sg(cr) * ((5 * mg(cr)) >> 5));
    r[9] = 16'(cy + sg(sr) * ((5 * mg(sr)) >> 5));
    return r;
  endfunction

  function automatic int eff_angle(input int prev, input int ang);
    int r;
    r = (ang >= 360) ? ang - 360 : ang;
`ifdef MAP_SEQ_ANGLE_SLEW_EN
    begin
      int d, st;
      d = (r - prev + 360) % 360;
      if (d == 0) return prev;
      if (d <= 180) begin
        st = (d < 5) ? d : 5;
        return (prev + st) % 360;
      end
      st = ((360 - d) < 5) ? (360 - d) : 5;
      return (prev + 360 - st) % 360;
    end
`else
    if (prev < 0) return 0;
    return r;
`endif
  endfunction

  task automatic do_frame(input int bx, input int by, input int ang);
    @(negedge clk);
    ballx = 16'(bx); bally = 16'(by); angle = 16'(ang); new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0; ballx = 16'($urandom); bally = 16'($urandom);
    got_trig[0] = trig;
    @(negedge clk); got_trig[1] = trig;
    @(negedge clk); got_trig[2] = trig;
    @(negedge clk);
    @(negedge clk); got_pre = obs; done_e4 = frame_done; busy_e4 = busy;
    @(negedge clk); got_post = obs; done_e5 = frame_done; busy_e5 = busy;
    @(negedge clk); done_e6 = frame_done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (obs !== '0) begin fails++; $display("FAIL reset_outputs got=%h want=0", obs); end
    tests++; if (trig !== 16'd0) begin fails++; $display("FAIL reset_trig got=%0d want=0", trig); end
    tests++; if ({params_valid, busy, frame_done, overrun} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got=%b want=0000", {params_valid, busy, frame_done, overrun});
    end
    rst_n = 1'b1;
    a_model = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [9:0][15:0] exp;
    exp = {16'd688, 16'd754, 16'd752, 16'd754, 16'hFFFF, 16'd275, 16'd1441, 16'd275, 16'd720, 16'd776};
    a_model = eff_angle(a_model, 0);
    do_frame(0, 0, 0);
    tests++; if (got_pre !== '0) begin fails++; $display("FAIL basic_pre_commit got=%h want=0", got_pre); end
    tests++; if (got_post !== exp) begin fails++; $display("FAIL basic_values got=%h want=%h", got_post, exp); end
    tests++; if ({done_e4, done_e5, done_e6} !== 3'b010) begin
      fails++; $display("FAIL basic_done_pulse got=%b want=010", {done_e4, done_e5, done_e6});
    end
    tests++; if ({busy_e4, busy_e5} !== 2'b10) begin
      fails++; $display("FAIL basic_busy got=%b want=10", {busy_e4, busy_e5});
    end
    tests++; if (params_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got=%b want=1", params_valid); end
  endtask

  task automatic test_trig_sequence;
    a_model = eff_angle(a_model, 0);
    do_frame(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0);
    tests++; if ({got_trig[0], got_trig[1], got_trig[2]} !== {16'd0, 16'd55, 16'd305}) begin
      fails++; $display("FAIL trig_sequence got=%0d,%0d,%0d want=0,55,305", got_trig[0], got_trig[1], got_trig[2]);
    end
  endtask

  task automatic test_overrun;
    int bx1, by1, bx2, by2;
    logic [9:0][15:0] exp;
    bx1 = int'($urandom_range(0, 65535)); by1 = int'($urandom_range(0, 65535));
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_initial got=%b want=0", overrun); end
    a_model = eff_angle(a_model, 0);
    exp = model(bx1, by1, a_model);
    @(negedge clk); ballx = 16'(bx1); bally = 16'(by1); angle = 16'd0; new_frame = 1'b1;
    @(negedge clk); new_frame = 1'b0; ballx = 16'h1234; bally = 16'h4321;
    @(negedge clk); new_frame = 1'b1; angle = 16'd200;
    @(negedge clk); new_frame = 1'b0;
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got=%b want=1", overrun); end
    repeat (3) @(negedge clk);
    tests++; if (obs !== exp) begin fails++; $display("FAIL overrun_values got=%h want=%h", obs, exp); end
    bx2 = int'($urandom_range(0, 65535)); by2 = int'($urandom_range(0, 65535));
    a_model = eff_angle(a_model, 123);
    do_frame(bx2, by2, 123);
    exp = model(bx2, by2, a_model);
    tests++; if (got_post !== exp) begin fails++; $display("FAIL overrun_next_frame got=%h want=%h", got_post, exp); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_reset_mid;
    int bx, by, ang;
    logic [9:0][15:0] exp;
    @(negedge clk); ballx = 16'd9000; bally = 16'd7000; angle = 16'd77; new_frame = 1'b1;
    @(negedge clk); new_frame = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    tests++; if (obs !== '0) begin fails++; $display("FAIL midreset_outputs got=%h want=0", obs); end
    tests++; if ({trig, params_valid, busy, frame_done, overrun} !== 20'd0) begin
      fails++; $display("FAIL midreset_state trig=%0d flags=%b want 0", trig, {params_valid, busy, frame_done, overrun});
    end
    @(negedge clk); rst_n = 1'b1; a_model = 0;
    @(negedge clk); @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_idle busy=%b want=0", busy); end
    bx = int'($urandom_range(0, 65535)); by = int'($urandom_range(0, 65535)); ang = int'($urandom_range(0, 719));
    a_model = eff_angle(a_model, ang);
    do_frame(bx, by, ang);
    exp = model(bx, by, a_model);
    tests++; if (got_post !== exp) begin fails++; $display("FAIL midreset_recover got=%h want=%h", got_post, exp); end
  endtask

`ifdef MAP_SEQ_ANGLE_SLEW_EN
  task automatic test_slew;
    int want [3] = '{355, 350, 350};
    test_reset;
    for (int i = 0; i < 3; i++) begin
      a_model = eff_angle(a_model, 350);
      do_frame(1000, 2000, 350);
      tests++; if (int'(got_trig[0]) != want[i]) begin
        fails++; $display("FAIL slew_step%0d got=%0d want=%0d", i, got_trig[0], want[i]);
      end
    end
  endtask
`else
  task automatic test_angle_reduce;
    logic [9:0][15:0] exp;
    a_model = eff_angle(a_model, 400);
    do_frame(4321, 8765, 400);
    tests++; if ({got_trig[0], got_trig[1], got_trig[2]} !== {16'd40, 16'd95, 16'd345}) begin
      fails++; $display("FAIL angle_reduce_trig got=%0d,%0d,%0d want=40,95,345", got_trig[0], got_trig[1], got_trig[2]);
    end
    exp = model(4321, 8765, 40);
    tests++; if (got_post !== exp) begin fails++; $display("FAIL angle_reduce_values got=%h want=%h", got_post, exp); end
  endtask
`endif

  task automatic test_random;
    int bx, by, ang, a;
    logic [9:0][15:0] exp, prev;
    prev = obs;
    for (int i = 0; i < 24; i++) begin
      bx = int'($urandom_range(0, 65535)); by = int'($urandom_range(0, 65535)); ang = int'($urandom_range(0, 719));
      a_model = eff_angle(a_model, ang);
      a = a_model;
      exp = model(bx, by, a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_frame(bx, by, ang);
      tests++; if ({got_trig[0], got_trig[1], got_trig[2]} !== {16'(a), 16'((a + 55) % 360), 16'((a + 305) % 360)}) begin
        fails++; $display("FAIL rand%0d_trig got=%0d,%0d,%0d a=%0d", i, got_trig[0], got_trig[1], got_trig[2], a);
      end
      tests++; if (got_pre !== prev) begin fails++; $display("FAIL rand%0d_hold got=%h want=%h", i, got_pre, prev); end
      tests++; if (got_post !== exp) begin fails++; $display("FAIL rand%0d_values got=%h want=%h", i, got_post, exp); end
      tests++; if ({done_e4, done_e5, done_e6} !== 3'b010) begin
        fails++; $display("FAIL rand%0d_done got=%b want=010", i, {done_e4, done_e5, done_e6});
      end
      prev = exp;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_trig_sequence;
    test_overrun;
    test_reset_mid;
`ifdef MAP_SEQ_ANGLE_SLEW_EN
    test_slew;
`else
    test_angle_reduce;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/map_frame_sequencer.md
# map_frame_sequencer

Per-frame camera/frustum parameter controller for the ground-plane map renderer. It latches ball position and heading once per frame at the vblank start pulse and time-shares a single external cos/sin lookup across the three view angles. It computes the camera position and the four frustum corners sequentially, then publishes them atomically, so the per-pixel renderer sees parameters that are constant for a whole frame and needs no trig instances of its own.

## Interface
- MAX_SLEW, default 5: maximum heading change per frame in degrees; used only with slew enabled.
- HALF_FOV, default 55: half field of view in degrees.
- pixel_clk_in  in  1  sole clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- new_frame_in  in  1  one-cycle pulse at vblank start.
- ballx_in, bally_in  in  16 each  ball position in fixed point; bits [15:5] are used.
- angle_in  in  16  heading in degrees; valid range 0..719; values ≥360 are reduced by subtracting 360.
- trig_angle_out  out  16  angle presented to the lookup, in 0..359.
- cos_abs_in, sin_abs_in  in  16 each  lookup magnitudes, scaled by 256; registered, valid 1 cycle after trig_angle_out.
- cos_sign_in, sin_sign_in  in  1 each  1 means negative.
- cam_x_out, cam_y_out  out  16 each  camera position.
- farl_x_out, farl_y_out, farr_x_out, farr_y_out  out  16 each  far corners, left and right.
- nearl_x_out, nearl_y_out, nearr_x_out, nearr_y_out  out  16 each  near corners, left and right.
- params_valid_out  out  1  set after the first commit; sticky until reset.
- busy_out  out  1  high in every state except IDLE.
- frame_done_out  out  1  one-cycle pulse on the commit cycle.
- overrun_out  out  1  sticky; set when new_frame_in arrives while busy.

## Operation
- States: IDLE → TRIG_C → CAM → CORN_L → CORN_R → COMMIT → IDLE.
- IDLE:
  - Waits for new_frame_in.
  - Latches pos_x = ballx_in[15:5] + 720, pos_y = bally_in[15:5] + 720, and the effective angle a.
- TRIG_C: drives trig_angle_out = a.
- CAM:
  - Samples the lookup for a.
  - cam_x = pos_x + s(cos_sign)·((7·cos_abs)>>5).
  - cam_y = pos_y − s(sin_sign)·((7·sin_abs)>>5).
  - s(0) = +1, s(1) = −1.
  - Drives trig_angle_out = (a + HALF_FOV) mod 360.
- CORN_L:
  - Samples the left-angle lookup.
  - For each magnitude m ∈ {FAR_MAG = 110, NEAR_MAG = 5}: x = cam_x − s(cos_sign)·((m·cos_abs)>>5); y = cam_y + s(sin_sign)·((m·sin_abs)>>5).
  - Drives trig_angle_out = (a + 360 − HALF_FOV) mod 360.
- CORN_R: same arithmetic as CORN_L for the right corners.
- COMMIT: copies all 10 shadow registers to the outputs in the same cycle and pulses frame_done_out.
- Arithmetic:
  - Products are 32-bit unsigned; shift before add/subtract.
  - Results are truncated to 16 bits and wrap mod 2^16; there is no saturation.
- Trig sign convention: the lookup's angle-sign semantics define the frustum orientation; this block only applies the formulas above.
- new_frame_in while busy: ignored and sets overrun_out; the running computation completes unaffected.
- Outputs change only in COMMIT; they are never partially updated.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; all outputs 0, including trig_angle_out, the valid flag and the sticky flags.
- Cycle numbering: new_frame_in sampled high at edge E0.
  - Outputs and frame_done_out change at E5.
  - busy_out is high from E0 to E5.
- Lookup latency is exactly 1 cycle; the block never waits on it.
- Minimum pulse spacing accepted: 6 cycles. A pulse arriving one cycle after COMMIT is accepted.
- Reset mid-sequence discards the shadow registers; outputs return to 0.

## Configuration
- MAP_SEQ_ANGLE_SLEW_EN defined:
  - a moves from its previous value toward angle_in along the shortest arc, by at most MAX_SLEW per frame, wrapping mod 360.
  - Reset value of a is 0.
  - A difference of exactly 180 steps positive.
- Undefined: a = reduced angle_in directly.

## Structure
- Package map_pkg holds:
  - state enum typedef;
  - constants BALL_DEPTH = 7, NEAR_MAG = 5, FAR_MAG = 110, MAP_ORIGIN = 720, COS_HALF_FOV = 146.
- One sub-module, map_axis_step: combinational base ± s(sign)·((mag·abs)>>5) with an add/subtract select. It is instanced twice (x and y) and reused across states.

## Test plan
Bench drives the trig port with a stub that returns:
- 0°: cos 256/+, sin 0/+.
- 55°: cos 146/+, sin 210/+.
- 305°: cos 146/+, sin 210/−.

Scenarios:
- Slew off, ballx = bally = 0, angle 0, new_frame pulse:
  - At E5: cam = (776, 720); farl = (275, 1441); farr = (275, 0xFFFF); nearl = (754, 752); nearr = (754, 688).
  - frame_done_out is a single-cycle pulse; params_valid_out = 1.
- trig_angle_out sequence on consecutive cycles after the pulse is exactly 0, 55, 305.
- Second pulse at E2 of a sequence: overrun_out = 1; outputs equal the first frame's values; the next legal pulse still completes.
- Reset asserted at E3: all outputs 0 immediately; after release the state is IDLE and busy_out = 0.
- Slew on, MAX_SLEW = 5, angle_in 350 held across frames from reset: trig angles at TRIG_C are 355, 350, 350.
- angle_in = 400, slew off: trig angles are 40, 95, 345.
